stage_indicator_buzzer: RTL and testbench

Parametrised washer front-panel indicator and buzzer controller. Drives one light per program stage, with the active stage blinking from an internal blink generator. Drives a run/start light. Runs a buzzer pattern engine: a single beep on any key press, and a configurable multi-beep finish sequence that raises a done flag. It sits between the program sequencer (run_state, stage, finish) and the panel LED/buzzer pins, and generalises the fixed 3-light, 4-key, 9-beep panel logic.

---
 rtl/stage_indicator_buzzer.sv | 171 +++++++++++++++++
 tb/tb_stage_indicator_buzzer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_indicator_buzzer.sv
// Washer front-panel controller: stage lights with a blinking active stage,
// run light, and a buzzer engine for key beeps and the finish beep sequence.
module stage_indicator_buzzer #(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_KEYS     = 4,
  parameter int BEEP_TICKS   = 25_000_000,
  parameter int BLINK_TICKS  = 50_000_000,
  parameter int FINISH_BEEPS = 9,
  parameter int CNT_W        = 32,
  parameter int SW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  power,
  input  logic [1:0]            run_state,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [SW-1:0]         cur_stage,
  input  logic                  finish,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [NUM_STAGES-1:0] stage_light,
  output logic                  start_light,
  output logic                  buzzer,
  output logic                  done,
  output logic                  busy
);

  localparam int NBW = (FINISH_BEEPS > 1) ? $clog2(FINISH_BEEPS) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST  = CNT_W'(BEEP_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [NBW-1:0]   NBEEP_LAST = NBW'(FINISH_BEEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_BEEP,
    S_FIN_ON,
    S_FIN_OFF,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bcnt_q, bcnt_d;
  logic [NBW-1:0]          nbeep_q, nbeep_d;
  logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_q, blink_d;
  logic [NUM_KEYS-1:0]     key_q;
  logic [NUM_STAGES-1:0]   stage_light_q, stage_light_d;
  logic                    start_light_q, start_light_d;
  logic                    buzzer_q, buzzer_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   stage_sel;
  logic                    any_rise;
  logic                    running;

  // One-hot select of the executing stage; stays all-zero when cur_stage is out of range.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
    assign stage_sel[gi] = (cur_stage == SW'(gi));
  end

  assign any_rise = |(keys & ~key_q);
  assign running  = (run_state == 2'b01);

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_comb begin
    stage_light_d = stage_mask;
    if (running) begin
      if (finish) stage_light_d = '1;
      else        stage_light_d = (stage_mask & ~stage_sel) | (stage_sel & {NUM_STAGES{blink_q}});
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    nbeep_d = nbeep_q;
    case (state_q)
      S_IDLE: begin
        if (any_rise) begin
          state_d = S_KEY_BEEP;
          bcnt_d  = '0;
        end else if (finish) begin
          state_d = S_FIN_ON;
          bcnt_d  = '0;
          nbeep_d = '0;
        end
      end
      S_KEY_BEEP: begin
        if (bcnt_q == BEEP_LAST) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_FIN_ON: begin
        if (!finish) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q == BEEP_LAST) begin
          bcnt_d  = '0;
          state_d = (nbeep_q == NBEEP_LAST) ? S_DONE : S_FIN_OFF;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_FIN_OFF: begin
        if (!finish) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q == BEEP_LAST) begin
          state_d = S_FIN_ON;
          bcnt_d  = '0;
          nbeep_d = nbeep_q + 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the next state so buzzer/done/start_light change on the same edge.
  always_comb begin
    buzzer_d      = (state_d == S_KEY_BEEP) || (state_d == S_FIN_ON);
    done_d        = (state_d == S_DONE);
    start_light_d = running && !done_d;
  end

  always_ff @(posedge clk) begin
    if (reset || !power) begin
      state_q       <= S_IDLE;
      bcnt_q        <= '0;
      nbeep_q       <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      key_q         <= '0;
      stage_light_q <= '0;
      start_light_q <= 1'b0;
      buzzer_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      nbeep_q       <= nbeep_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      key_q         <= keys;
      stage_light_q <= stage_light_d;
      start_light_q <= start_light_d;
      buzzer_q      <= buzzer_d;
      done_q        <= done_d;
    end
  end

  assign stage_light = stage_light_q;
  assign start_light = start_light_q;
  assign buzzer      = buzzer_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_stage_indicator_buzzer.sv
// Self-checking bench for stage_indicator_buzzer: directed scenarios plus random
// traffic, all compared against a timeline-based reference model.
module tb_stage_indicator_buzzer;

  localparam int NS     = 3;
  localparam int NK     = 4;
  localparam int BEEP   = 4;
  localparam int BLINK  = 2;
  localparam int FB     = 3;
  localparam int FINLEN = (2 * FB - 1) * BEEP;

  logic          clk = 1'b0;
  logic          reset, power, finish;
  logic [1:0]    run_state;
  logic [NS-1:0] stage_mask;
  logic [1:0]    cur_stage;
  logic [NK-1:0] keys;
  logic [NS-1:0] stage_light;
  logic          start_light, buzzer, done, busy;
  logic [6:0]    obs;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 key beep, 2 finish timeline (t = cycles since start)
  int            m_mode, m_t, m_k;
  logic [NK-1:0] m_prev_keys;
  logic [NS-1:0] m_stage;
  logic          m_start, m_buzz, m_done, m_busy;

  stage_indicator_buzzer #(
    .NUM_STAGES(NS), .NUM_KEYS(NK), .BEEP_TICKS(BEEP), .BLINK_TICKS(BLINK),
    .FINISH_BEEPS(FB), .CNT_W(8), .SW(2)
  ) dut (
    .clk(clk), .reset(reset), .power(power), .run_state(run_state),
    .stage_mask(stage_mask), .cur_stage(cur_stage), .finish(finish), .keys(keys),
    .stage_light(stage_light), .start_light(start_light), .buzzer(buzzer),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {stage_light, start_light, buzzer, done, busy};

  function automatic logic [6:0] exp_vec();
    return {m_stage, m_start, m_buzz, m_done, m_busy};
  endfunction

  task automatic model_step();
    logic          rise;
    logic          blink_now;
    logic [NS-1:0] s;
    if (reset || !power) begin
      m_mode = 0; m_t = 0; m_k = 0; m_prev_keys = '0;
      m_stage = '0; m_start = 0; m_buzz = 0; m_done = 0; m_busy = 0;
    end else begin
      rise      = |(keys & ~m_prev_keys);
      blink_now = ((m_k / BLINK) % 2) == 1;
      s = stage_mask;
      if (run_state == 2'b01) begin
        if (finish) s = '1;
        else if (int'(cur_stage) < NS) s[cur_stage] = blink_now;
      end
      m_stage = s;
      case (m_mode)
        0: if (rise) begin m_mode = 1; m_t = 0; end
           else if (finish) begin m_mode = 2; m_t = 0; end
        1: if (m_t == BEEP - 1) m_mode = 0; else m_t++;
        default: if (!finish) m_mode = 0; else if (m_t < FINLEN) m_t++;
      endcase
      m_buzz  = (m_mode == 1) || (m_mode == 2 && m_t < FINLEN && ((m_t / BEEP) % 2) == 0);
      m_done  = (m_mode == 2) && (m_t >= FINLEN);
      m_busy  = (m_mode != 0);
      m_start = (run_state == 2'b01) && !m_done;
      m_prev_keys = keys;
      m_k++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; power = 1; finish = 0; run_state = 2'b01; stage_mask = 3'b111;
    cur_stage = 1; keys = '0;
    tick(); tick();
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, 7'b0); end
    reset = 0; finish = 1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b1 || buzzer !== 1'b0) begin
      errors++; $display("FAIL reach_fin_off: got busy=%b buzzer=%b expected busy=1 buzzer=0", busy, buzzer);
    end
    reset = 1; tick();
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_mid_finish: got %b expected %b", obs, 7'b0); end
    reset = 0;
    for (int i = 0; i < 6; i++) tick();
    power = 0; tick();
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL power_off_mid_finish: got %b expected %b", obs, 7'b0); end
    power = 1; finish = 0; run_state = 2'b00;
    tick(); tick();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_recover: got %b expected %b", obs, exp_vec()); end
  endtask

  task automatic test_key_beep();
    int highs = 0;
    keys = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) keys = 4'b0101;
      highs += int'(buzzer);
      if (i == 0) begin
        checks++;
        if (buzzer !== 1'b1) begin errors++; $display("FAIL key_beep_start: got %b expected 1", buzzer); end
      end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL key_beep_cycle%0d: got %b expected %b", i, obs, exp_vec()); end
    end
    checks++;
    if (highs != BEEP) begin errors++; $display("FAIL key_beep_length: got %0d expected %0d", highs, BEEP); end
    keys = '0; tick();
  endtask

  task automatic test_blink();
    int dim = 0;
    run_state = 2'b01; stage_mask = 3'b111; cur_stage = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (stage_light == 3'b101) dim++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL blink_cycle%0d: got %b expected %b", i, obs, exp_vec()); end
    end
    checks++;
    if (dim != 4) begin errors++; $display("FAIL blink_duty: got %0d dim cycles expected 4", dim); end
    run_state = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (stage_light !== 3'b111) begin errors++; $display("FAIL paused_steady: got %b expected 111", stage_light); end
    end
    run_state = 2'b01; stage_mask = 3'b101; cur_stage = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (stage_light !== 3'b101) begin errors++; $display("FAIL out_of_range_stage: got %b expected 101", stage_light); end
    end
  endtask

  task automatic test_finish();
    logic [FINLEN-1:0] pat = '0;
    logic [FINLEN-1:0] want;
    want = {FINLEN{1'b0}};
    for (int b = 0; b < FINLEN; b++) want[FINLEN-1-b] = ((b / BEEP) % 2) == 0;
    run_state = 2'b01; stage_mask = 3'b111; cur_stage = 0; finish = 1;
    for (int i = 0; i <= FINLEN; i++) begin
      tick();
      if (i < FINLEN) pat[FINLEN-1-i] = buzzer;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL finish_cycle%0d: got %b expected %b", i, obs, exp_vec()); end
    end
    checks++;
    if (pat !== want) begin errors++; $display("FAIL finish_pattern: got %b expected %b", pat, want); end
    checks++;
    if ({done, buzzer, start_light, stage_light} !== 6'b100111) begin
      errors++; $display("FAIL finish_done: got done=%b buz=%b start=%b stage=%b expected 1 0 0 111",
                         done, buzzer, start_light, stage_light);
    end
    finish = 0; tick();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL finish_release: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_abort();
    finish = 1;
    for (int i = 0; i < 2 * BEEP + 1; i++) tick();
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL second_beep_on: got %b expected 1", buzzer); end
    finish = 0; tick();
    checks++;
    if ({buzzer, busy, done} !== 3'b000) begin errors++; $display("FAIL abort: got %b expected 000", {buzzer, busy, done}); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pat = '0;
    keys = 4'b0001; finish = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      pat[11-i] = buzzer;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL priority_cycle%0d: got %b expected %b", i, obs, exp_vec()); end
    end
    checks++;
    if (pat !== 12'b1111_0_1111_000) begin errors++; $display("FAIL key_over_finish: got %b expected 111101111000", pat); end
    finish = 0; keys = '0; tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      power = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 7) == 0) keys = NK'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) finish = ~finish;
      if ($urandom_range(0, 15) == 0) run_state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) stage_mask = NS'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) cur_stage = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d: got %b expected %b", i, obs, exp_vec()); end
    end
    reset = 0; power = 1;
  endtask

  initial begin
    test_reset();
    test_key_beep();
    test_blink();
    test_finish();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
